// File: rtl/knob_slew_if.sv
// knob_slew_if: detent index / vsync in, live parameter and status flags out.
interface knob_slew_if #(
    parameter int unsigned IW = 4,
    parameter int unsigned W  = 8
);
    logic [IW-1:0] idx;
    logic          vs;
    logic [W-1:0]  value;
    logic          busy;
    logic          chg;
    logic          osd;

    modport master (output idx, output vs, input value, input busy, input chg, input osd);
    modport slave  (input idx, input vs, output value, output busy, output chg, output osd);
endinterface

// File: rtl/knob_slew.sv
// knob_slew: maps a detent index to a W-bit parameter and moves it toward that target only on frame pulses.
// Macro KNOB_SLEW_EN: defined -> at most RATE per frame; undefined -> jump to target on each frame pulse.
module knob_slew #(
    parameter int unsigned N    = 12,
    parameter int unsigned INIT = 0,
    parameter int unsigned W    = 8,
    parameter int unsigned BASE = 0,
    parameter int unsigned STEP = 16,
    parameter int unsigned RATE = 4,
    parameter int unsigned HOLD = 60
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    knob_slew_if.slave   bus
);
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW   = $clog2(HOLD + 1);
    localparam logic [31:0] VMAX = 32'((64'(1) << W) - 64'(1));
`ifdef KNOB_SLEW_EN
    localparam logic [31:0] LIM  = 32'(RATE);
`else
    // Limit never below full scale, so a single step always reaches the target.
    localparam logic [31:0] LIM  = 32'(RATE) | VMAX;
`endif

    // Linear index-to-value map with index clamp and saturation.
    function automatic logic [W-1:0] map_idx(input logic [IW-1:0] i);
        logic [31:0] ic;
        logic [31:0] v;
        ic = (32'(i) >= N - 1) ? 32'(N - 1) : 32'(i);
        v  = BASE + ic * STEP;
        return (v > VMAX) ? W'(VMAX) : W'(v);
    endfunction

    localparam logic [IW-1:0] INIT_IDX = IW'(INIT);
    localparam logic [W-1:0]  INIT_VAL = map_idx(INIT_IDX);

    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  value_q, value_d;
    logic          vs_q, vs_d;
    logic          chg_q, chg_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          fr;
    logic          idx_chg;
    logic [W-1:0]  diff;
    logic [W-1:0]  step;

    always_comb begin
        fr       = bus.vs & ~vs_q;
        idx_chg  = (bus.idx != idx_q);
        idx_d    = bus.idx;
        target_d = map_idx(bus.idx);
        chg_d    = idx_chg;
        vs_d     = bus.vs;
        hold_d   = hold_q;
        value_d  = value_q;
        diff     = (value_q < target_q) ? (target_q - value_q) : (value_q - target_q);
        step     = (32'(diff) > LIM) ? W'(LIM) : diff;

        // A new index reloads the window; the load takes priority over the frame decrement.
        if (idx_chg) begin
            hold_d = HW'(HOLD);
        end else if (fr && (hold_q != '0)) begin
            hold_d = hold_q - HW'(1);
        end

        // Step is clamped to the remaining distance, so no overshoot or wrap.
        if (fr) begin
            if (value_q < target_q) begin
                value_d = value_q + step;
            end else if (value_q > target_q) begin
                value_d = value_q - step;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q    <= INIT_IDX;
            target_q <= INIT_VAL;
            value_q  <= INIT_VAL;
            vs_q     <= 1'b0;
            chg_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            target_q <= target_d;
            value_q  <= value_d;
            vs_q     <= vs_d;
            chg_q    <= chg_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.value = value_q;
    assign bus.busy  = (value_q != target_q);
    assign bus.chg   = chg_q;
    assign bus.osd   = (hold_q != '0);
endmodule
